// File: rtl/digit_chain_counter_if.sv
// -----------------------------------------------------------------------------
// digit_chain_counter_if
//   Control and status bundle of the cascaded modulo-N digit counter.
//
//   Signals (direction seen from the counter, i.e. the slave modport):
//     en          in   count enable; 0 = hold
//     up_dn       in   1 = count up, 0 = count down
//     clr         in   synchronous clear, active-high
//     load        in   parallel load strobe, active-high
//     load_val    in   DIGITS*DIGIT_W load value, digit 0 in LSBs
//     count_out   out  DIGITS*DIGIT_W registered count, digit 0 in LSBs
//     tc          out  terminal count in the current direction (combinational)
//     wrap_pulse  out  one-cycle registered pulse per boundary event
//     ovf         out  sticky boundary flag
//
//   master modport : whoever drives the controls (game datapath, testbench)
//   slave modport  : the counter itself
// -----------------------------------------------------------------------------
interface digit_chain_counter_if #(
  parameter int DIGITS  = 2,
  parameter int DIGIT_W = 4
);

  logic                      en;
  logic                      up_dn;
  logic                      clr;
  logic                      load;
  logic [DIGITS*DIGIT_W-1:0] load_val;
  logic [DIGITS*DIGIT_W-1:0] count_out;
  logic                      tc;
  logic                      wrap_pulse;
  logic                      ovf;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  count_out, tc, wrap_pulse, ovf
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output count_out, tc, wrap_pulse, ovf
  );

endinterface : digit_chain_counter_if

// File: rtl/digit_chain_counter.sv
// -----------------------------------------------------------------------------
// digit_chain_counter
//   DIGITS cascaded modulo-MODULUS digits with up/down counting, parallel load
//   (out-of-range fields clamp to MODULUS-1), synchronous clear and a
//   wrap-or-saturate boundary mode. A boundary event (enable while at terminal
//   count) raises a one-cycle registered wrap_pulse and sets the sticky ovf.
//
//   Parameters:
//     DIGITS    number of cascaded digits (>= 1)
//     DIGIT_W   bits per digit
//     MODULUS   counts per digit, 2 <= MODULUS <= 2**DIGIT_W
//     SATURATE  0: wrap at either end, 1: hold at either end
//
//   Ports:
//     clk   clock, all state updates on the rising edge
//     rst   synchronous reset, active-low; overrides every other input
//     bus   digit_chain_counter_if slave modport (controls in, status out)
//
//   Edge priority: rst > clr > load > en > hold.
// -----------------------------------------------------------------------------
module digit_chain_counter #(
  parameter int DIGITS   = 2,
  parameter int DIGIT_W  = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_chain_counter_if.slave  bus
);

  // Highest legal digit value, and MODULUS widened by one bit so a full-range
  // digit field can be compared against it without truncation.
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(MODULUS - 1);
  localparam logic [DIGIT_W:0]   MOD_EXT   = (DIGIT_W + 1)'(MODULUS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIGIT_W-1:0] r_digit [DIGITS];
  logic               r_wrap_pulse;
  logic               r_ovf;

  // ---------------------------------------------------------------------------
  // Candidate next values
  // ---------------------------------------------------------------------------
  logic [DIGIT_W-1:0] w_digit_up   [DIGITS];
  logic [DIGIT_W-1:0] w_digit_dn   [DIGITS];
  logic [DIGIT_W-1:0] w_digit_load [DIGITS];
  logic [DIGIT_W-1:0] w_digit_next [DIGITS];
  logic               w_all_max;
  logic               w_all_zero;
  logic               w_tc;
  logic               w_boundary;
  logic               w_wrap_next;
  logic               w_ovf_next;

  // Ripple carry/borrow chain. A digit steps only when every lower digit sits
  // at the extreme for the current direction; digit 0 always steps. When the
  // chain runs off the top digit the whole counter is at terminal count, and
  // the per-digit roll-over already produces the wrapped value (all-0 going
  // up, all-MAX going down), so no separate wrap path is needed.
  always_comb begin : carry_chain
    logic w_carry;
    logic w_borrow;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_carry    = 1'b1;
    w_borrow   = 1'b1;
    w_all_max  = 1'b0;
    w_all_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_digit_up[i] = r_digit[i];
      w_digit_dn[i] = r_digit[i];

      if (w_carry) begin
        w_digit_up[i] = (r_digit[i] == DIGIT_MAX) ? '0 : r_digit[i] + DIGIT_W'(1);
      end
      if (w_borrow) begin
        w_digit_dn[i] = (r_digit[i] == '0) ? DIGIT_MAX : r_digit[i] - DIGIT_W'(1);
      end

      w_carry  = w_carry  && (r_digit[i] == DIGIT_MAX);
      w_borrow = w_borrow && (r_digit[i] == '0);
    end
    w_all_max  = w_carry;
    w_all_zero = w_borrow;
  end

  // Load path: each field is clamped into 0..MODULUS-1 so digits can never
  // hold an illegal value, whatever the upstream logic presents.
  always_comb begin : load_clamp
    for (int i = 0; i < DIGITS; i++) begin
      w_digit_load[i] = bus.load_val[i*DIGIT_W +: DIGIT_W];
      if ({1'b0, bus.load_val[i*DIGIT_W +: DIGIT_W]} >= MOD_EXT) begin
        w_digit_load[i] = DIGIT_MAX;
      end
    end
  end

  // Terminal count follows the live direction input with no register stage,
  // so a direction change is honoured on the very edge it is sampled.
  assign w_tc       = bus.up_dn ? w_all_max : w_all_zero;
  assign w_boundary = bus.en && w_tc;

  // Next-state selection in edge priority order (reset is applied in the
  // register process since it overrides everything).
  always_comb begin : next_state
    w_digit_next = r_digit;
    w_wrap_next  = 1'b0;
    w_ovf_next   = r_ovf;

    if (bus.clr) begin
      for (int i = 0; i < DIGITS; i++) begin
        w_digit_next[i] = '0;
      end
      w_ovf_next = 1'b0;
    end else if (bus.load) begin
      w_digit_next = w_digit_load;
    end else if (bus.en) begin
      if (w_boundary) begin
        w_wrap_next = 1'b1;
        w_ovf_next  = 1'b1;
      end
      // In saturate mode the boundary event freezes the count; otherwise the
      // carry chain's natural roll-over is the wrap.
      if (!(w_boundary && (SATURATE != 0))) begin
        w_digit_next = bus.up_dn ? w_digit_up : w_digit_dn;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the digit array is a handful of flops rather than a RAM, so it is
  // reset explicitly; the count must read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      for (int i = 0; i < DIGITS; i++) begin
        r_digit[i] <= '0;
      end
      r_wrap_pulse <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_digit      <= w_digit_next;
      r_wrap_pulse <= w_wrap_next;
      r_ovf        <= w_ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin : pack_count
    bus.count_out = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bus.count_out[i*DIGIT_W +: DIGIT_W] = r_digit[i];
    end
  end

  assign bus.tc         = w_tc;
  assign bus.wrap_pulse = r_wrap_pulse;
  assign bus.ovf        = r_ovf;

endmodule : digit_chain_counter

// File: tb/tb_digit_chain_counter.sv
// -----------------------------------------------------------------------------
// tb_digit_chain_counter
//   Two counters (wrap and saturate mode) driven with identical stimulus.
//   Directed vectors from a table, hand-written multi-cycle sequences, then
//   randomized traffic compared against an integer-valued reference model.
// -----------------------------------------------------------------------------
module tb_digit_chain_counter;

  localparam int DIGITS  = 2;
  localparam int DIGIT_W = 4;
  localparam int MODULUS = 10;
  localparam int NB      = DIGITS * DIGIT_W;
  localparam int MAXV    = MODULUS ** DIGITS - 1;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  digit_chain_counter_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) bus0 ();
  digit_chain_counter_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) bus1 ();

  digit_chain_counter #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MODULUS(MODULUS), .SATURATE(0)
  ) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  digit_chain_counter #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MODULUS(MODULUS), .SATURATE(1)
  ) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [NB-1:0] lv);
    bus0.en = e; bus0.up_dn = u; bus0.clr = c; bus0.load = l; bus0.load_val = lv;
    bus1.en = e; bus1.up_dn = u; bus1.clr = c; bus1.load = l; bus1.load_val = lv;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Integer value -> packed digits, digit 0 in LSBs.
  function automatic logic [NB-1:0] enc(input int v);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(v % MODULUS);
      v = v / MODULUS;
    end
    return r;
  endfunction

  // Packed load value -> integer, each field clamped to MODULUS-1.
  function automatic int dec_clamp(input logic [NB-1:0] lv);
    int v;
    int w;
    int f;
    v = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      f = int'(lv[i*DIGIT_W +: DIGIT_W]);
      if (f >= MODULUS) f = MODULUS - 1;
      v += f * w;
      w *= MODULUS;
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vector table (checked against the wrap-mode counter)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          clr;
    logic          load;
    logic          en;
    logic          up;
    logic [NB-1:0] lv;
    logic [NB-1:0] exp_cnt;
    logic          exp_tc;
    logic          exp_wrap;
    logic          exp_ovf;
  } vec_t;

  vec_t tbl[$];

  // Reference model state, index 0 = wrap mode, 1 = saturate mode
  int m_val [2];
  bit m_ovf [2];
  bit m_wrap[2];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //                 clr load en up  lv      cnt     tc wrap ovf
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'h5C, 8'h59, 1'b0, 1'b0, 1'b0}); // clamp, load beats en
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h60, 1'b0, 1'b0, 1'b0}); // carry
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0, 1'b0, 1'b0}); // borrow
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0}); // 0x09 -> 0x10
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0, 1'b0}); // 0x10 -> 0x09
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b1, 1'b0, 1'b0}); // tc up
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1}); // wrap up
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1}); // pulse drops
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b1}); // wrap down
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0}); // clr beats load
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h37, 8'h37, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h99, 1'b0, 1'b0, 1'b0}); // both clamp
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 8'h90, 1'b0, 1'b0, 1'b0}); // upper clamp

    // ---- Reset: two cycles with en=1, nothing counts -------------------------
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    tick();
    check("rst_cnt_wrap", 32'(bus0.count_out), 32'(8'h00));
    check("rst_pulse_wrap", 32'(bus0.wrap_pulse), 0);
    check("rst_ovf_wrap", 32'(bus0.ovf), 0);
    check("rst_cnt_sat", 32'(bus1.count_out), 32'(8'h00));
    check("rst_ovf_sat", 32'(bus1.ovf), 0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    check("post_rst_hold", 32'(bus0.count_out), 32'(8'h00));

    // ---- Table -------------------------------------------------------------
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].load, tbl[i].lv);
      tick();
      check($sformatf("vec%0d_cnt", i), 32'(bus0.count_out), 32'(tbl[i].exp_cnt));
      check($sformatf("vec%0d_tc", i), 32'(bus0.tc), 32'(tbl[i].exp_tc));
      check($sformatf("vec%0d_wrap", i), 32'(bus0.wrap_pulse), 32'(tbl[i].exp_wrap));
      check($sformatf("vec%0d_ovf", i), 32'(bus0.ovf), 32'(tbl[i].exp_ovf));
    end

    // ---- Hold: en=0 at 0x37 for 5 cycles ------------------------------------
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h37);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_cnt", 32'(bus0.count_out), 32'(8'h37));
      check("hold_pulse", 32'(bus0.wrap_pulse), 0);
    end

    // ---- Full up sweep: 99 edges to 0x99, 100th wraps ------------------------
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 99; i++) tick();
    check("sweep_cnt99", 32'(bus0.count_out), 32'(8'h99));
    check("sweep_tc", 32'(bus0.tc), 1);
    check("sweep_ovf_before", 32'(bus0.ovf), 0);
    tick();
    check("sweep_wrap_cnt", 32'(bus0.count_out), 32'(8'h00));
    check("sweep_wrap_pulse", 32'(bus0.wrap_pulse), 1);
    check("sweep_wrap_ovf", 32'(bus0.ovf), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check("sweep_pulse_1cyc", 32'(bus0.wrap_pulse), 0);
    check("sweep_ovf_sticky", 32'(bus0.ovf), 1);

    // ---- Reset mid-count at a boundary: no wrap pulse -----------------------
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    tick();
    check("midrst_cnt", 32'(bus0.count_out), 32'(8'h00));
    check("midrst_pulse", 32'(bus0.wrap_pulse), 0);
    check("midrst_ovf", 32'(bus0.ovf), 0);
    rst = 1'b1;

    // ---- Clear mid-count ----------------------------------------------------
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    check("midclr_cnt", 32'(bus0.count_out), 32'(8'h00));
    check("midclr_pulse", 32'(bus0.wrap_pulse), 0);

    // ---- Saturate mode ------------------------------------------------------
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_up_cnt", 32'(bus1.count_out), 32'(8'h99));
      check("sat_up_pulse", 32'(bus1.wrap_pulse), 1);
      check("sat_up_ovf", 32'(bus1.ovf), 1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    check("sat_load_keeps_ovf", 32'(bus1.ovf), 1);
    check("sat_load_pulse", 32'(bus1.wrap_pulse), 0);
    check("sat_tc_dn", 32'(bus1.tc), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check("sat_dn_cnt", 32'(bus1.count_out), 32'(8'h00));
    check("sat_dn_pulse", 32'(bus1.wrap_pulse), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("sat_clr_ovf", 32'(bus1.ovf), 0);
    check("sat_clr_pulse", 32'(bus1.wrap_pulse), 0);

    // ---- Randomized traffic vs. integer reference model ---------------------
    for (int k = 0; k < 2; k++) begin
      m_val[k]  = 0;
      m_ovf[k]  = 1'b0;
      m_wrap[k] = 1'b0;
    end
    begin
      logic          r_en;
      logic          r_up;
      logic          r_clr;
      logic          r_load;
      logic [NB-1:0] r_lv;
      logic [NB-1:0] act_cnt [2];
      logic          act_tc  [2];
      logic          act_wr  [2];
      logic          act_ov  [2];
      bool_loop : for (int cyc = 0; cyc < 600; cyc++) begin
        r_en   = ($urandom_range(0, 3) != 0);
        r_clr  = ($urandom_range(0, 40) == 0);
        r_load = ($urandom_range(0, 12) == 0);
        if (cyc == 0 || $urandom_range(0, 7) == 0) r_up = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       r_lv = 8'h99;
          1:       r_lv = 8'h00;
          2:       r_lv = 8'h01;
          default: r_lv = NB'($urandom);
        endcase
        drive(r_en, r_up, r_clr, r_load, r_lv);
        tick();

        for (int k = 0; k < 2; k++) begin
          m_wrap[k] = 1'b0;
          if (r_clr) begin
            m_val[k] = 0;
            m_ovf[k] = 1'b0;
          end else if (r_load) begin
            m_val[k] = dec_clamp(r_lv);
          end else if (r_en) begin
            if ((r_up && m_val[k] == MAXV) || (!r_up && m_val[k] == 0)) begin
              m_wrap[k] = 1'b1;
              m_ovf[k]  = 1'b1;
              if (k == 0) m_val[k] = r_up ? 0 : MAXV;
            end else begin
              m_val[k] = r_up ? m_val[k] + 1 : m_val[k] - 1;
            end
          end
        end

        act_cnt[0] = bus0.count_out; act_tc[0] = bus0.tc;
        act_wr[0]  = bus0.wrap_pulse; act_ov[0] = bus0.ovf;
        act_cnt[1] = bus1.count_out; act_tc[1] = bus1.tc;
        act_wr[1]  = bus1.wrap_pulse; act_ov[1] = bus1.ovf;

        for (int k = 0; k < 2; k++) begin
          check($sformatf("rnd%0d_m%0d_cnt", cyc, k), 32'(act_cnt[k]), 32'(enc(m_val[k])));
          check($sformatf("rnd%0d_m%0d_tc", cyc, k), 32'(act_tc[k]),
                32'((r_up && m_val[k] == MAXV) || (!r_up && m_val[k] == 0)));
          check($sformatf("rnd%0d_m%0d_wrap", cyc, k), 32'(act_wr[k]), 32'(m_wrap[k]));
          check($sformatf("rnd%0d_m%0d_ovf", cyc, k), 32'(act_ov[k]), 32'(m_ovf[k]));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_digit_chain_counter
